// File: rtl/bp_predec_ras.sv
// bp_predec_ras: registered branch pre-decoder predicting the next fetch PC,
// with an internal return-address stack for call/return pairs.
module bp_predec_ras #(
    parameter int RISCV_ARCH = 64,
    parameter int RAS_DEPTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_flush,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_c_valid,
    input  logic [RISCV_ARCH-1:0] i_addr,
    input  logic [31:0]           i_data,
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic                  o_jmp,
    output logic [RISCV_ARCH-1:0] o_pc,
    output logic [RISCV_ARCH-1:0] o_npc,
    output logic                  o_ras_empty
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [RISCV_ARCH-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]         r_ptr;
    logic [CW-1:0]         r_cnt;
    logic                  r_valid;
    logic                  r_jmp;
    logic [RISCV_ARCH-1:0] r_pc;
    logic [RISCV_ARCH-1:0] r_npc;

    logic                  w_accept;
    logic                  w_jal;
    logic                  w_br;
    logic                  w_cj;
    logic                  w_ret;
    logic                  w_is_ret;
    logic                  w_has_ret;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_jmp;
    logic [PW-1:0]         w_ptr_m1;
    logic [RISCV_ARCH-1:0] w_off;
    logic [RISCV_ARCH-1:0] w_npc;

    assign o_req_ready  = !r_valid | i_resp_ready;
    assign w_accept     = i_req_valid & o_req_ready & !i_flush;
    assign o_resp_valid = r_valid;
    assign o_jmp        = r_jmp;
    assign o_pc         = r_pc;
    assign o_npc        = r_npc;
    assign o_ras_empty  = r_cnt == '0;

    assign w_jal     = i_data[6:0] == 7'h6F;
    assign w_br      = i_data[6:0] == 7'h63 && i_data[31];
    assign w_cj      = i_c_valid && i_data[15:13] == 3'b101 && i_data[1:0] == 2'b01;
    assign w_ret     = i_data == 32'h0000_8067 || (i_c_valid && i_data[15:0] == 16'h8082);
    assign w_is_ret  = w_ret & !w_jal & !w_br & !w_cj;
    assign w_has_ret = w_is_ret & (r_cnt != '0);
    assign w_ptr_m1  = r_ptr - PW'(1);
    assign w_jmp     = w_jal | w_br | w_cj | w_has_ret;
    assign w_push    = w_accept & w_jal & (i_data[11:7] == 5'd1 || i_data[11:7] == 5'd5);
    assign w_pop     = w_accept & w_has_ret;

    always_comb begin
        w_off = w_jal ? {{(RISCV_ARCH-21){i_data[31]}}, i_data[31], i_data[19:12], i_data[20], i_data[30:21], 1'b0}
              : w_br  ? {{(RISCV_ARCH-13){i_data[31]}}, i_data[31], i_data[7], i_data[30:25], i_data[11:8], 1'b0}
              :         {{(RISCV_ARCH-12){i_data[12]}}, i_data[12], i_data[8], i_data[10:9], i_data[6],
                         i_data[7], i_data[2], i_data[11], i_data[5:3], 1'b0};
        w_npc = (w_jal | w_br | w_cj)              ? i_addr + w_off
              : w_has_ret                          ? r_ras[w_ptr_m1]
              : (i_c_valid && i_data[1:0] != 2'b11) ? i_addr + RISCV_ARCH'(2)
              :                                      i_addr + RISCV_ARCH'(4);
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_valid <= 1'b0;
            r_jmp   <= 1'b0;
            r_pc    <= '0;
            r_npc   <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_jmp   <= w_jmp;
            r_pc    <= i_addr;
            r_npc   <= w_npc;
        end else if (i_resp_ready) begin
            r_valid <= 1'b0;
        end
    end

    // A push onto a full stack overwrites the oldest entry; the count saturates.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_ptr <= '0;
            r_cnt <= '0;
            for (int k = 0; k < RAS_DEPTH; k++) r_ras[k] <= '0;
        end else if (w_push) begin
            r_ras[r_ptr] <= i_addr + RISCV_ARCH'(4);
            r_ptr        <= r_ptr + PW'(1);
            r_cnt        <= (r_cnt == CW'(RAS_DEPTH)) ? r_cnt : r_cnt + CW'(1);
        end else if (w_pop) begin
            r_ptr <= w_ptr_m1;
            r_cnt <= r_cnt - CW'(1);
        end
    end
endmodule

// File: tb/tb_bp_predec_ras.sv
// tb_bp_predec_ras: directed vectors with hand-computed predictions.
module tb_bp_predec_ras;
    logic        i_clk = 1'b0;
    logic        i_nrst = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_c_valid = 1'b0;
    logic [63:0] i_addr = '0;
    logic [31:0] i_data = '0;
    logic        o_resp_valid;
    logic        i_resp_ready = 1'b1;
    logic        o_jmp;
    logic [63:0] o_pc;
    logic [63:0] o_npc;
    logic        o_ras_empty;
    int          n_err = 0;
    int          n_chk = 0;

    bp_predec_ras #(.RISCV_ARCH(64), .RAS_DEPTH(8)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_flush(i_flush),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_c_valid(i_c_valid), .i_addr(i_addr), .i_data(i_data),
        .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_jmp(o_jmp), .o_pc(o_pc), .o_npc(o_npc), .o_ras_empty(o_ras_empty)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [63:0] a, input logic [31:0] d, input logic c);
        i_addr = a;
        i_data = d;
        i_c_valid = c;
        i_req_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
    endtask

    task automatic resp(input string tag, input logic j, input logic [63:0] npc, input logic e);
        chk({tag, "_valid"}, 64'(o_resp_valid), 64'd1);
        chk({tag, "_jmp"}, 64'(o_jmp), 64'(j));
        chk({tag, "_npc"}, o_npc, npc);
        chk({tag, "_empty"}, 64'(o_ras_empty), 64'(e));
    endtask

    initial begin
        // T1 reset
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_valid", 64'(o_resp_valid), 64'd0);
        chk("rst_jmp", 64'(o_jmp), 64'd0);
        chk("rst_pc", o_pc, 64'd0);
        chk("rst_npc", o_npc, 64'd0);
        chk("rst_empty", 64'(o_ras_empty), 64'd1);
        chk("rst_ready", 64'(o_req_ready), 64'd1);
        i_nrst = 1'b1;
        // T2 / T3
        send(64'h1000, 32'h008000EF, 1'b0);
        resp("jal_ra", 1'b1, 64'h1008, 1'b0);
        chk("jal_pc", o_pc, 64'h1000);
        send(64'h1008, 32'h00008067, 1'b0);
        resp("ret", 1'b1, 64'h1004, 1'b1);
        // T4
        send(64'h2000, 32'h00008082, 1'b1);
        resp("cret_empty", 1'b0, 64'h2002, 1'b1);
        // other decode cases
        send(64'h5000, 32'hFE000EE3, 1'b0);
        resp("br_neg", 1'b1, 64'h4FFC, 1'b1);
        send(64'h5000, 32'h00000463, 1'b1);
        resp("br_pos", 1'b0, 64'h5004, 1'b1);
        send(64'h6000, 32'h0000A011, 1'b1);
        resp("cj_pos", 1'b1, 64'h6004, 1'b1);
        send(64'h6000, 32'h0000BFFD, 1'b1);
        resp("cj_neg", 1'b1, 64'h5FFE, 1'b1);
        send(64'h6000, 32'h0000A011, 1'b0);
        resp("cj_noc", 1'b0, 64'h6004, 1'b1);
        send(64'h6100, 32'h0080006F, 1'b0);
        resp("j_x0", 1'b1, 64'h6108, 1'b1);
        // T5 overflow: pushed return addresses 0x100..0x900, one via rd=t0
        for (int k = 1; k <= 9; k++) begin
            send(64'(k) * 64'h100 - 64'd4, (k == 5) ? 32'h008002EF : 32'h008000EF, 1'b0);
            chk("push_empty", 64'(o_ras_empty), 64'd0);
        end
        for (int k = 9; k >= 2; k--) begin
            send(64'h3000, 32'h00008067, 1'b0);
            chk("pop_jmp", 64'(o_jmp), 64'd1);
            chk("pop_npc", o_npc, 64'(k) * 64'h100);
        end
        chk("pop_all_empty", 64'(o_ras_empty), 64'd1);
        send(64'h3000, 32'h00008067, 1'b0);
        resp("pop_extra", 1'b0, 64'h3004, 1'b1);
        // T6 backpressure then flush
        @(posedge i_clk);
        #1;
        chk("drain_valid", 64'(o_resp_valid), 64'd0);
        i_resp_ready = 1'b0;
        send(64'h4000, 32'h008000EF, 1'b0);
        resp("bp_first", 1'b1, 64'h4008, 1'b0);
        for (int k = 0; k < 3; k++) begin
            i_addr = 64'h7000;
            i_data = 32'h00000013;
            i_req_valid = 1'b1;
            #1;
            chk("bp_ready", 64'(o_req_ready), 64'd0);
            @(posedge i_clk);
            #1;
            chk("bp_valid", 64'(o_resp_valid), 64'd1);
            chk("bp_pc", o_pc, 64'h4000);
            chk("bp_npc", o_npc, 64'h4008);
        end
        i_resp_ready = 1'b1;
        i_flush = 1'b1;
        send(64'h8000, 32'h008000EF, 1'b0);
        i_flush = 1'b0;
        chk("flush_valid", 64'(o_resp_valid), 64'd0);
        chk("flush_empty", 64'(o_ras_empty), 64'd0);
        send(64'h9000, 32'h00008067, 1'b0);
        resp("flush_ret", 1'b1, 64'h4004, 1'b1);
        send(64'h9000, 32'h00008067, 1'b0);
        resp("flush_ret2", 1'b0, 64'h9004, 1'b1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
